// File: rtl/salsa_stream_ctrl.sv
// salsa_stream_ctrl
// Drives a Salsa20 hash core and turns its keystream into a byte-stream cipher.
// The block holds a 12-word config file: key[0..7], nonce[0..1] and the 64-bit
// block position pos[0..1]. For each block it loads those words into the core,
// captures the 64 keystream bytes the core emits, then XORs them one-for-one
// with plaintext bytes to produce ciphertext on a registered valid/ready output.
// With AUTO_INC=1 the block position advances once per fully captured block,
// so back-to-back blocks walk through the keystream without software help.
module salsa_stream_ctrl #(
    parameter bit AUTO_INC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        run,
    input  logic        abort,
    input  logic        pt_valid,
    input  logic [7:0]  pt_data,
    output logic        pt_ready,
    output logic        ct_valid,
    output logic [7:0]  ct_data,
    input  logic        ct_ready,
    output logic        busy,
    output logic        hash_reset,
    output logic        hash_start,
    output logic [31:0] hash_data_in,
    input  logic        hash_ready,
    input  logic        hash_writes,
    input  logic [7:0]  hash_data_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STREAM  = 3'd4
    } state_t;

    // Config file layout: words 0-7 key, 8-9 nonce, 10-11 block position.
    // The LOAD sequence walks the file in address order, so the load counter
    // doubles as the config read address.
    localparam logic [3:0] CFG_WORDS  = 4'd12;
    localparam logic [3:0] LAST_LOAD  = 4'd11;
    localparam int         POS_LO     = 10;
    localparam int         POS_HI     = 11;
    localparam logic [5:0] LAST_BYTE  = 6'd63;

    state_t      state;
    state_t      state_next;

    logic [31:0] cfg_file [0:11];
    logic [3:0]  load_cnt;
    logic [5:0]  wr_idx;
    logic [5:0]  rd_idx;
    logic [7:0]  ks_buf [0:63];

    logic        abort_evt;
    logic        capture_we;
    logic        capture_done;
    logic        pt_fire;
    logic        cfg_wr_en;
    logic [63:0] pos_inc;

    // An explicit abort, or the core dropping hash_writes before all 64 bytes
    // arrived, cancels the current block. Aborts are meaningless in IDLE.
    assign abort_evt = (state != ST_IDLE) &&
                       (abort || ((state == ST_CAPTURE) && !hash_writes));

    // Byte 0 is taken in WAIT (the first hash_writes cycle), bytes 1..63 in
    // CAPTURE, so the write index is already 1 when CAPTURE begins.
    assign capture_we   = ((state == ST_WAIT) || (state == ST_CAPTURE)) &&
                          hash_writes && !abort_evt;
    assign capture_done = capture_we && (state == ST_CAPTURE) && (wr_idx == LAST_BYTE);

    assign pt_fire   = pt_valid && pt_ready;
    assign cfg_wr_en = (state == ST_IDLE) && cfg_we && (cfg_addr < CFG_WORDS);

    // 64-bit position with carry from the low word into the high word;
    // all-ones wraps to zero naturally.
    assign pos_inc = {cfg_file[POS_HI], cfg_file[POS_LO]} + 64'd1;

    // Status and handshake outputs decoded straight from the state.
    assign busy       = (state != ST_IDLE);
    assign pt_ready   = (state == ST_STREAM) && (!ct_valid || ct_ready);
    assign hash_reset = reset || abort_evt;

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values; blocking assignments
    // here would make the result depend on process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the hash-core load outputs.
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        hash_start   = 1'b0;
        hash_data_in = '0;
        case (state)
            ST_IDLE: begin
                if (run && hash_ready && !abort) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hash_start   = (load_cnt == 4'd0);
                hash_data_in = cfg_file[load_cnt];
                if (load_cnt == LAST_LOAD) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hash_writes) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (capture_done) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // The only exit point is the handshake of the last buffered
                // byte; run is sampled here and nowhere else in the block.
                if (pt_fire && (rd_idx == LAST_BYTE)) begin
                    state_next = (run && hash_ready) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_evt) begin
            state_next = ST_IDLE;
        end
    end

    // LOAD cycle counter: runs 0..11 while in LOAD, parked at 0 elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt <= '0;
        end else if ((state == ST_LOAD) && !abort_evt && (load_cnt != LAST_LOAD)) begin
            load_cnt <= load_cnt + 4'd1;
        end else begin
            load_cnt <= '0;
        end
    end

    // Config file: host writes only while idle; the position words also
    // advance once per completed capture when auto-increment is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) begin
                cfg_file[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            cfg_file[cfg_addr] <= cfg_data;
        end else if (AUTO_INC && capture_done) begin
            cfg_file[POS_LO] <= pos_inc[31:0];
            cfg_file[POS_HI] <= pos_inc[63:32];
        end
    end

    // Keystream write index: restarts for every block and on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx <= '0;
        end else if (abort_evt || (state == ST_IDLE) || (state == ST_LOAD)) begin
            wr_idx <= '0;
        end else if (capture_we) begin
            wr_idx <= wr_idx + 6'd1;
        end
    end

    // Keystream buffer storage.
    // NOTE: the buffer has no reset; its contents are only ever read after a
    // full 64-byte capture has overwritten every entry, so clearing it would
    // cost reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (capture_we) begin
            ks_buf[wr_idx] <= hash_data_out;
        end
    end

    // Keystream read index: zero on STREAM entry, one step per accepted byte.
    // Resetting it outside STREAM is what discards a buffer on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx <= '0;
        end else if (abort_evt || (state != ST_STREAM)) begin
            rd_idx <= '0;
        end else if (pt_fire) begin
            rd_idx <= rd_idx + 6'd1;
        end
    end

    // Ciphertext output register: loads on a plaintext handshake, empties on
    // ct_ready, and keeps draining independently of the state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            ct_valid <= 1'b0;
            ct_data  <= '0;
        end else if (abort_evt) begin
            ct_valid <= 1'b0;
        end else if (pt_fire) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ ks_buf[rd_idx];
        end else if (ct_ready) begin
            ct_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_salsa_stream_ctrl.sv
// Self-checking bench for salsa_stream_ctrl. A behavioural stand-in for the
// hash core emits a known keystream pattern derived from a per-block seed, so
// ciphertext can be predicted as plaintext XOR that pattern.
module tb_salsa_stream_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        run;
    logic        abort;
    logic        pt_valid;
    logic [7:0]  pt_data;
    logic        pt_ready;
    logic        ct_valid;
    logic [7:0]  ct_data;
    logic        ct_ready;
    logic        busy;
    logic        hash_reset;
    logic        hash_start;
    logic [31:0] hash_data_in;
    logic        hash_ready;
    logic        hash_writes;
    logic [7:0]  hash_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got [12];

    salsa_stream_ctrl #(.AUTO_INC(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .run          (run),
        .abort        (abort),
        .pt_valid     (pt_valid),
        .pt_data      (pt_data),
        .pt_ready     (pt_ready),
        .ct_valid     (ct_valid),
        .ct_data      (ct_data),
        .ct_ready     (ct_ready),
        .busy         (busy),
        .hash_reset   (hash_reset),
        .hash_start   (hash_start),
        .hash_data_in (hash_data_in),
        .hash_ready   (hash_ready),
        .hash_writes  (hash_writes),
        .hash_data_out(hash_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        reset;
        logic        cfg_we;
        logic [3:0]  cfg_addr;
        logic [31:0] cfg_data;
        logic        run;
        logic        abort;
        logic        hash_ready;
        logic        exp_busy;
        logic        exp_hash_reset;
        logic        exp_hash_start;
        logic [31:0] exp_hash_data_in;
        logic        exp_pt_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, {24'd0, act}, {24'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] key_word(input int i);
        int b;
        b = 4 * i;
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    // Keystream pattern produced by the stand-in hash core.
    function automatic logic [7:0] ks_byte(input logic [7:0] seed, input int k);
        int v;
        v = k * 37 + int'(seed) * 13 + 90;
        return 8'(v);
    endfunction

    function automatic void add(input logic rst, input logic we, input logic [3:0] addr,
                                input logic [31:0] data, input logic r, input logic ab,
                                input logic hr, input logic e_busy, input logic e_hres,
                                input logic e_start, input logic [31:0] e_din,
                                input logic e_ptr);
        vec_t v;
        v.reset = rst; v.cfg_we = we; v.cfg_addr = addr; v.cfg_data = data;
        v.run = r; v.abort = ab; v.hash_ready = hr;
        v.exp_busy = e_busy; v.exp_hash_reset = e_hres; v.exp_hash_start = e_start;
        v.exp_hash_data_in = e_din; v.exp_pt_ready = e_ptr;
        vecs.push_back(v);
    endfunction

    // Waits (bounded) for hash_start, then records the 12 LOAD words.
    // Returns one cycle into WAIT.
    task automatic run_load();
        int n;
        n = 0;
        #1;
        while (hash_start !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        check_bit("load_start_seen", hash_start, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                tick();
                #1;
                check_bit($sformatf("load_start_low_c%0d", i), hash_start, 1'b0);
            end
            got[i] = hash_data_in;
        end
        tick();
        #1;
        check("wait_data_in_zero", hash_data_in, 32'h0);
        check_bit("wait_busy", busy, 1'b1);
    endtask

    // Stand-in core: idle for gap cycles in WAIT, then emit n keystream bytes.
    task automatic emit(input logic [7:0] seed, input int n, input int gap);
        hash_ready = 1'b0;
        for (int g = 0; g < gap; g++) begin
            #1;
            check_bit("wait_no_pt_ready", pt_ready, 1'b0);
            tick();
        end
        for (int k = 0; k < n; k++) begin
            hash_writes   = 1'b1;
            hash_data_out = ks_byte(seed, k);
            tick();
        end
        hash_writes   = 1'b0;
        hash_data_out = 8'h00;
        hash_ready    = 1'b1;
    endtask

    // Streams one 64-byte block. mode 0: pt=0x00, no stalls. mode 1: pt
    // pattern, pt_valid gaps and ct_ready back-pressure. run is switched to
    // run_after once 10 bytes have been accepted.
    task automatic stream_block(input logic [7:0] seed, input int mode, input logic run_after);
        int sent;
        int cyc;
        logic m_valid;
        logic [7:0] m_data;
        logic exp_ready;
        logic [7:0] ptb;
        sent = 0; cyc = 0; m_valid = 1'b0; m_data = 8'h00;
        while (sent < 64 && cyc < 400) begin
            ct_ready = (mode == 0) ? 1'b1 : (cyc % 3 != 2);
            pt_valid = (mode == 0) ? 1'b1 : (cyc % 5 != 3);
            ptb      = (mode == 0) ? 8'h00 : (8'(sent) ^ 8'hA5);
            pt_data  = ptb;
            if (sent >= 10) run = run_after;
            #1;
            check_bit($sformatf("s%0d ct_valid c%0d", seed, cyc), ct_valid, m_valid);
            if (m_valid) check_byte($sformatf("s%0d ct_data c%0d", seed, cyc), ct_data, m_data);
            exp_ready = !m_valid || ct_ready;
            check_bit($sformatf("s%0d pt_ready c%0d", seed, cyc), pt_ready, exp_ready);
            tick();
            if (exp_ready && pt_valid) begin
                m_data  = ptb ^ ks_byte(seed, sent);
                m_valid = 1'b1;
                sent++;
            end else if (ct_ready) begin
                m_valid = 1'b0;
            end
            cyc++;
        end
        check("stream_bytes_sent", 32'(sent), 32'd64);
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        #1;
        check_bit("drain_ct_valid", ct_valid, m_valid);
        check_byte("drain_ct_data", ct_data, m_data);
        check_bit("drain_pt_ready", pt_ready, 1'b0);
        check_bit("after_block_busy", busy, run && hash_ready);
    endtask

    initial begin : main
        logic [7:0] held;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 32'h0;
        run = 1'b0; abort = 1'b0; pt_valid = 1'b0; pt_data = 8'h00; ct_ready = 1'b1;
        hash_ready = 1'b0; hash_writes = 1'b0; hash_data_out = 8'h00;
        repeat (2) tick();

        // ---- table: reset, config writes, start gating, LOAD word order ----
        add(1, 0, 4'd0,  32'h0,         0, 0, 0, 0, 1, 0, 32'h0, 0);
        add(1, 1, 4'd10, 32'hFFFF_FFFF, 1, 1, 1, 0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 4'(i), key_word(i), 0, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 1, 4'd8,  32'h4E4F_4E30, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 1, 4'd9,  32'h4E4F_4E31, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 1, 4'd12, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0,  32'h0,         1, 1, 1, 0, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0,  32'h0,         1, 0, 0, 0, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0,  32'h0,         1, 0, 1, 0, 0, 0, 32'h0, 0);
        add(0, 1, 4'd11, 32'hCAFE_F00D, 0, 0, 0, 1, 0, 1, key_word(0), 0);
        for (int i = 1; i < 8; i++)
            add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, key_word(i), 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h4E4F_4E30, 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h4E4F_4E31, 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        add(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].reset; cfg_we = vecs[i].cfg_we; cfg_addr = vecs[i].cfg_addr;
            cfg_data = vecs[i].cfg_data; run = vecs[i].run; abort = vecs[i].abort;
            hash_ready = vecs[i].hash_ready;
            #1;
            check_bit($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check_bit($sformatf("vec%0d hash_reset", i), hash_reset, vecs[i].exp_hash_reset);
            check_bit($sformatf("vec%0d hash_start", i), hash_start, vecs[i].exp_hash_start);
            check($sformatf("vec%0d hash_data_in", i), hash_data_in, vecs[i].exp_hash_data_in);
            check_bit($sformatf("vec%0d pt_ready", i), pt_ready, vecs[i].exp_pt_ready);
            tick();
        end

        // ---- block 0: capture, stream zeros, key0 write during STREAM dropped ----
        emit(8'h00, 64, 2);
        #1;
        check_bit("b0 stream pt_ready", pt_ready, 1'b1);
        check_bit("b0 stream busy", busy, 1'b1);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'hFFFF_FFFF; run = 1'b1;
        stream_block(8'h00, 0, 1'b1);
        cfg_we = 1'b0;
        run_load();
        check("b1 key0 unchanged", got[0], key_word(0));
        check("b1 nonce1", got[9], 32'h4E4F_4E31);
        check("b1 pos0 incremented", got[10], 32'h1);
        check("b1 pos1", got[11], 32'h0);

        // ---- block 1: stalls, run dropped mid-block, ends in IDLE ----
        emit(8'h01, 64, 1);
        #1;
        check_bit("b1 stream pt_ready", pt_ready, 1'b1);
        stream_block(8'h01, 1, 1'b0);

        // ---- position all-ones, abort in WAIT, config write right after ----
        cfg_we = 1'b1; cfg_addr = 4'd10; cfg_data = 32'hFFFF_FFFF;
        tick();
        cfg_addr = 4'd11;
        tick();
        cfg_we = 1'b0; run = 1'b1;
        run_load();
        check("ff pos0", got[10], 32'hFFFF_FFFF);
        check("ff pos1", got[11], 32'hFFFF_FFFF);
        abort = 1'b1; run = 1'b0;
        #1;
        check_bit("abort_wait hash_reset", hash_reset, 1'b1);
        tick();
        abort = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 32'h1234_5678;
        #1;
        check_bit("abort_wait idle", busy, 1'b0);
        check_bit("abort_wait hash_reset one cycle", hash_reset, 1'b0);
        tick();
        cfg_we = 1'b0; run = 1'b1;
        run_load();
        check("post_abort key2 written", got[2], 32'h1234_5678);
        check("post_abort pos0 unchanged", got[10], 32'hFFFF_FFFF);
        check("post_abort pos1 unchanged", got[11], 32'hFFFF_FFFF);

        // ---- position wrap ----
        emit(8'hFF, 64, 1);
        #1;
        check_bit("wrap stream pt_ready", pt_ready, 1'b1);
        stream_block(8'hFF, 0, 1'b1);
        run_load();
        check("wrap pos0", got[10], 32'h0);
        check("wrap pos1", got[11], 32'h0);

        // ---- hash_writes falls early: treated as abort ----
        emit(8'h00, 10, 2);
        #1;
        check_bit("underrun hash_reset", hash_reset, 1'b1);
        tick();
        #1;
        check_bit("underrun idle", busy, 1'b0);
        check_bit("underrun hash_reset one cycle", hash_reset, 1'b0);
        run_load();
        check("underrun pos0 unchanged", got[10], 32'h0);

        // ---- back-pressure hold, then abort in STREAM ----
        emit(8'h00, 64, 1);
        #1;
        pt_valid = 1'b1; pt_data = 8'h3C; ct_ready = 1'b0;
        #1;
        check_bit("bp first pt_ready", pt_ready, 1'b1);
        tick();
        held = 8'h3C ^ ks_byte(8'h00, 0);
        pt_data = 8'h77;
        #1;
        check_bit("bp ct_valid", ct_valid, 1'b1);
        check_byte("bp ct_data", ct_data, held);
        check_bit("bp pt_ready blocked", pt_ready, 1'b0);
        tick();
        #1;
        check_byte("bp ct_data stable", ct_data, held);
        abort = 1'b1;
        #1;
        check_bit("abort_stream hash_reset", hash_reset, 1'b1);
        tick();
        abort = 1'b0; pt_valid = 1'b0; ct_ready = 1'b1;
        #1;
        check_bit("abort_stream ct_valid cleared", ct_valid, 1'b0);
        check_bit("abort_stream idle", busy, 1'b0);
        check_bit("abort_stream pt_ready", pt_ready, 1'b0);

        // ---- reset mid-LOAD overrides abort and cfg_we, clears config ----
        tick();
        #1;
        check_bit("pre_reset in load", hash_start, 1'b1);
        reset = 1'b1; abort = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'hAAAA_5555;
        #1;
        check_bit("reset hash_reset", hash_reset, 1'b1);
        tick();
        reset = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        #1;
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset hash_start", hash_start, 1'b0);
        check("reset hash_data_in", hash_data_in, 32'h0);
        check_byte("reset ct_data", ct_data, 8'h00);
        run_load();
        check("reset key0 cleared", got[0], 32'h0);
        check("reset key7 cleared", got[7], 32'h0);
        check("reset pos0 cleared", got[10], 32'h0);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/salsa_stream_ctrl.md
SALSA_STREAM_CTRL -- requirements
Module: salsa_stream_ctrl

Interface
REQ-001 SHALL have parameter: AUTO_INC, 1, when 1 the 64-bit block position increments by 1 after every captured block; when 0 it is held.
REQ-002 SHALL have ports (name direction width meaning), one per line:
 clk  in  1  single clock, all logic on posedge
 reset  in  1  synchronous, active-high reset
 cfg_we  in  1  config write strobe
 cfg_addr  in  4  0-7 key[0..7], 8-9 nonce[0..1], 10-11 pos[0..1], 12-15 ignored
 cfg_data  in  32  config write data
 run  in  1  level; permits keystream generation
 abort  in  1  single-cycle abort of current operation
 pt_valid  in  1  plaintext byte valid
 pt_data  in  8  plaintext byte
 pt_ready  out  1  plaintext byte accepted when pt_valid & pt_ready
 ct_valid  out  1  ciphertext byte valid (registered)
 ct_data  out  8  ciphertext byte (registered)
 ct_ready  in  1  downstream accepts ct byte
 busy  out  1  high in every state except IDLE
 hash_reset  out  1  reset to hash core
 hash_start  out  1  start to hash core
 hash_data_in  out  32  word to hash core
 hash_ready  in  1  hash core idle
 hash_writes  in  1  hash core emitting keystream bytes
 hash_data_out  in  8  keystream byte from hash core
REQ-003 Clock and reset SHALL be named clk and reset; reset is synchronous, active-high.

Function
REQ-004 SHALL hold a 12-word config file; cfg_we writes cfg_data to cfg_addr only in IDLE; writes in any other state are dropped.
REQ-005 SHALL implement states IDLE, LOAD, WAIT, CAPTURE, STREAM.
REQ-006 IDLE->LOAD when run=1 & hash_ready=1 & abort=0.
REQ-007 LOAD SHALL last exactly 12 cycles; cycle 0 drives hash_start=1 with key[0]; cycles 1..11 drive, in order, key[1..7], nonce[0], nonce[1], pos[0], pos[1]; hash_start=0 in cycles 1..11; hash_data_in=0 outside LOAD.
REQ-008 LOAD->WAIT after cycle 11; WAIT->CAPTURE on first cycle hash_writes=1, capturing that cycle's hash_data_out as byte 0.
REQ-009 CAPTURE SHALL write hash_data_out into the 64x8 keystream buffer at index k each cycle hash_writes=1 (k=0..63); after byte 63, ->STREAM, read index=0, and if AUTO_INC=1, {pos[1],pos[0]} += 1 modulo 2^64 (wrap from all-ones to 0, carry from pos[0] into pos[1]).
REQ-010 hash_writes falling before 64 bytes captured SHALL be treated as abort (REQ-015).
REQ-011 pt_ready = (state==STREAM) & (!ct_valid | ct_ready).
REQ-012 On pt handshake: ct_data <= pt_data XOR buf[read index]; ct_valid <= 1; read index += 1; ct_valid clears on ct_ready when no new handshake; simultaneous ct_ready and new handshake keeps ct_valid=1 with new byte.
REQ-013 After handshake of byte 63: run=1 -> LOAD (next block) once hash_ready=1, else IDLE; ct register still drains normally.
REQ-014 run deasserted mid-STREAM SHALL not discard buffered bytes; transition decision made only at byte 63.
REQ-015 abort (any non-IDLE state): next state IDLE, hash_reset=1 for exactly one cycle, buffer bytes discarded, ct_valid cleared, position unchanged unless already incremented per REQ-009.
REQ-016 hash_reset SHALL also be 1 in every cycle reset=1.

Reset
REQ-017 On reset: state IDLE, config file all zero, read index 0, ct_valid=0, ct_data=0, hash_start=0, hash_data_in=0, busy=0, pt_ready=0, hash_reset=1.
REQ-018 reset mid-operation SHALL override abort, run and cfg_we in the same cycle.

Verification
REQ-019 Key 00..1F bytes, nonce 0, pos 0, run=1 -> hash_start one cycle, 12 words in REQ-007 order; with salsa_hash core first pt_ready 98 cycles after the hash_start cycle.
REQ-020 pt all 0x00 for 64 bytes, ct_ready=1 -> ct equals Salsa20 keystream block 0 byte-exact; pos becomes 1; second block loaded with pos[0]=1.
REQ-021 pos = 0xFFFFFFFF_FFFFFFFF, AUTO_INC=1 -> after one block pos[0]=0, pos[1]=0.
REQ-022 ct_ready=0 with ct_valid=1 -> pt_ready=0, ct_data stable; ct_ready=1 then -> next byte accepted same cycle.
REQ-023 abort in WAIT -> IDLE next cycle, one-cycle hash_reset, pos unchanged, cfg_we accepted next cycle.
REQ-024 cfg_we to key[0] during STREAM -> ignored; key[0] readback via next LOAD unchanged.
